// File: rtl/unary_add_driver.sv
// Driver/collector for the unary adder: serializes two operand lengths onto A/B, then
// drains dout/C and reassembles the binary sum. Optional compare: UNARY_ADD_SELF_CHECK_EN.
`timescale 1ns/1ps

module unary_add_driver #(
    parameter int LEN_W = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] a_len,
    input  logic [LEN_W-1:0] b_len,
    output logic             ready,
    output logic             A,
    output logic             B,
    output logic             en,
    output logic             read_or_write,
    input  logic             dout,
    input  logic             C,
    output logic             done,
    output logic [LEN_W:0]   sum,
    output logic [LEN_W:0]   carries
`ifdef UNARY_ADD_SELF_CHECK_EN
    ,
    output logic             mismatch
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // One counter serves both the SEND index and the FLUSH/DRAIN cycle count.
    localparam int CW = (LEN_W > CNT_W + 1) ? LEN_W : CNT_W + 1;
    localparam logic [CW-1:0] FLUSH_LAST = CW'(1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2 ** CNT_W);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0] a_len_q, a_len_d;
    logic [LEN_W-1:0] b_len_q, b_len_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [LEN_W:0]   carr_q, carr_d;
    logic [LEN_W:0]   sum_q, sum_d;
    logic [LEN_W:0]   carries_q, carries_d;
    logic             ready_q, ready_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             en_q, en_d;
    logic             rw_q, rw_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] max_len;
    logic [CW-1:0]    send_last;
    logic             active;
`ifdef UNARY_ADD_SELF_CHECK_EN
    logic             mismatch_q, mismatch_d;
    logic [LEN_W:0]   expected_sum;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_len_d   = a_len_q;
        b_len_d   = b_len_q;
        ones_d    = ones_q;
        carr_d    = carr_q;
        sum_d     = sum_q;
        carries_d = carries_q;
`ifdef UNARY_ADD_SELF_CHECK_EN
        mismatch_d   = mismatch_q;
        expected_sum = {1'b0, a_len_q} + {1'b0, b_len_q};
`endif
        max_len   = (a_len_q > b_len_q) ? a_len_q : b_len_q;
        send_last = CW'(max_len) - CW'(1);
        active    = (state_q == S_SEND) || (state_q == S_FLUSH) || (state_q == S_DRAIN);

        if (active && C && (carr_q != '1)) carr_d = carr_q + 1'b1;
        if ((state_q == S_DRAIN) && dout)  ones_d = ones_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_len_d   = a_len;
                    b_len_d   = b_len;
                    ones_d    = '0;
                    carr_d    = '0;
                    sum_d     = '0;
                    carries_d = '0;
                    cnt_d     = '0;
`ifdef UNARY_ADD_SELF_CHECK_EN
                    mismatch_d = 1'b0;
`endif
                    state_d   = ((a_len == '0) && (b_len == '0)) ? S_FLUSH : S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q == send_last) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    // Final-edge samples are folded in by using the next accumulator values.
                    sum_d     = {carr_d[LEN_W-CNT_W:0], ones_d};
                    carries_d = carr_d;
`ifdef UNARY_ADD_SELF_CHECK_EN
                    mismatch_d = (sum_d != expected_sum);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        ready_d = (state_d == S_IDLE);
        en_d    = (state_d == S_SEND) || (state_d == S_FLUSH) || (state_d == S_DRAIN);
        rw_d    = (state_d == S_DRAIN);
        a_d     = (state_d == S_SEND) && (cnt_d < CW'(a_len_d));
        b_d     = (state_d == S_SEND) && (cnt_d < CW'(b_len_d));
        done_d  = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only; async reset aborts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_len_q   <= '0;
            b_len_q   <= '0;
            ones_q    <= '0;
            carr_q    <= '0;
            sum_q     <= '0;
            carries_q <= '0;
            ready_q   <= 1'b1;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            en_q      <= 1'b0;
            rw_q      <= 1'b0;
            done_q    <= 1'b0;
`ifdef UNARY_ADD_SELF_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_len_q   <= a_len_d;
            b_len_q   <= b_len_d;
            ones_q    <= ones_d;
            carr_q    <= carr_d;
            sum_q     <= sum_d;
            carries_q <= carries_d;
            ready_q   <= ready_d;
            a_q       <= a_d;
            b_q       <= b_d;
            en_q      <= en_d;
            rw_q      <= rw_d;
            done_q    <= done_d;
`ifdef UNARY_ADD_SELF_CHECK_EN
            mismatch_q <= mismatch_d;
`endif
        end
    end

    assign ready         = ready_q;
    assign A             = a_q;
    assign B             = b_q;
    assign en            = en_q;
    assign read_or_write = rw_q;
    assign done          = done_q;
    assign sum           = sum_q;
    assign carries       = carries_q;
`ifdef UNARY_ADD_SELF_CHECK_EN
    assign mismatch      = mismatch_q;
`endif

endmodule

// File: tb/tb_unary_add_driver.sv
// Bench for unary_add_driver: drives directed transactions through a behavioural unary
// adder; a scoreboard queue holds expected results popped by a monitor on each done pulse.
`timescale 1ns/1ps

module tb_unary_add_driver;

    localparam int LEN_W = 3;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] a_len = '0;
    logic [LEN_W-1:0] b_len = '0;
    logic             ready, A, B, en, read_or_write, done;
    logic             dout, C;
    logic [LEN_W:0]   sum, carries;
`ifdef UNARY_ADD_SELF_CHECK_EN
    logic             mismatch;
`endif

    unary_add_driver #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_len(a_len), .b_len(b_len),
        .ready(ready), .A(A), .B(B), .en(en), .read_or_write(read_or_write),
        .dout(dout), .C(C), .done(done), .sum(sum), .carries(carries)
`ifdef UNARY_ADD_SELF_CHECK_EN
        , .mismatch(mismatch)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural unary adder: wrap raises a flag, the flag becomes C one edge later.
    logic [CNT_W-1:0] acc_m;
    logic             flag_m, c_m, dout_m;
    always @(posedge clk or negedge rst_n) begin
        logic [CNT_W:0] tmp;
        if (!rst_n) begin
            acc_m <= '0; flag_m <= 1'b0; c_m <= 1'b0; dout_m <= 1'b0;
        end else begin
            c_m <= flag_m;
            if (en && !read_or_write) begin
                tmp = {1'b0, acc_m} + {{CNT_W{1'b0}}, A} + {{CNT_W{1'b0}}, B};
                acc_m  <= tmp[CNT_W-1:0];
                flag_m <= tmp[CNT_W];
                dout_m <= 1'b0;
            end else if (en && read_or_write) begin
                flag_m <= 1'b0;
                if (acc_m != '0) begin
                    acc_m  <= acc_m - 1'b1;
                    dout_m <= 1'b1;
                end else begin
                    dout_m <= 1'b0;
                end
            end else begin
                flag_m <= 1'b0;
                dout_m <= 1'b0;
            end
        end
    end
    assign C    = c_m;
    assign dout = dout_m;

    typedef struct {
        int sum;
        int carries;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   accept_cyc = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: latency is counted in rising edges from the accepting edge to done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && start && ready) accept_cyc = cyc + 1;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: sum=%0d with no transaction queued", sum);
            end else begin
                e = sb.pop_front();
                check("sum", int'(sum), e.sum);
                check("carries", int'(carries), e.carries);
                check("latency", cyc - accept_cyc, e.lat);
                check("ready_in_done", int'(ready), 0);
`ifdef UNARY_ADD_SELF_CHECK_EN
                check("mismatch", int'(mismatch), 0);
`endif
            end
        end
    end

    task automatic issue(input int a, input int b, input int s, input int c, input int lat,
                         input bit push);
        exp_t e;
        @(posedge clk); #1;
        a_len = LEN_W'(a);
        b_len = LEN_W'(b);
        start = 1'b1;
        if (push) begin
            e.sum = s; e.carries = c; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end else begin
            @(posedge clk); #1;
            check("ready_after_done", int'(ready), 1);
            check("done_one_cycle", int'(done), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_en", int'(en), 0);
        check("rst_A", int'(A), 0);
        check("rst_B", int'(B), 0);
        check("rst_rw", int'(read_or_write), 0);
        check("rst_done", int'(done), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_carries", int'(carries), 0);
        rst_n = 1'b1;

        // 1+1: one SEND cycle, 2 FLUSH, 5 DRAIN.
        issue(1, 1, 2, 0, 8, 1'b1);
        check("t1_A", int'(A), 1);
        check("t1_B", int'(B), 1);
        check("t1_en", int'(en), 1);
        check("t1_rw", int'(read_or_write), 0);
        check("t1_ready", int'(ready), 0);
        wait_done();

        // 3+2: check the serialized waveform, then the hold of sum/carries.
        issue(3, 2, 5, 1, 10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t2_send_A", int'(A), (i < 3) ? 1 : 0);
            check("t2_send_B", int'(B), (i < 2) ? 1 : 0);
            check("t2_send_rw", int'(read_or_write), 0);
            @(posedge clk); #1;
        end
        for (int j = 0; j < 2; j++) begin
            check("t2_flush_en", int'(en), 1);
            check("t2_flush_rw", int'(read_or_write), 0);
            check("t2_flush_AB", int'({A, B}), 0);
            @(posedge clk); #1;
        end
        check("t2_drain_rw", int'(read_or_write), 1);
        check("t2_drain_en", int'(en), 1);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("t2_sum_hold", int'(sum), 5);
        check("t2_carries_hold", int'(carries), 1);

        // 0+0: straight into FLUSH.
        issue(0, 0, 0, 0, 7, 1'b1);
        check("t3_en", int'(en), 1);
        check("t3_rw", int'(read_or_write), 0);
        check("t3_AB", int'({A, B}), 0);
        wait_done();

        // 7+7: three carries, two leftover ones.
        issue(7, 7, 14, 3, 14, 1'b1);
        wait_done();

        // 5+5 with a stray start during SEND.
        issue(5, 5, 10, 2, 12, 1'b1);
        @(posedge clk); #1;
        start = 1'b1; a_len = 3'd1; b_len = 3'd1;
        check("t5_ready_send", int'(ready), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("t5_ready_send2", int'(ready), 0);
        wait_done();

        // Reset during DRAIN aborts; the next transaction runs cleanly.
        issue(3, 3, 0, 0, 0, 1'b0);
        n = 0;
        while (!read_or_write && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_reached_drain", int'(read_or_write), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_en", int'(en), 0);
        check("t6_rst_AB", int'({A, B}), 0);
        check("t6_rst_rw", int'(read_or_write), 0);
        check("t6_rst_sum", int'(sum), 0);
        check("t6_rst_ready", int'(ready), 1);
        check("t6_rst_done", int'(done), 0);
`ifdef UNARY_ADD_SELF_CHECK_EN
        check("t6_rst_mismatch", int'(mismatch), 0);
`endif
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(2, 1, 3, 0, 9, 1'b1);
        wait_done();

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
